// File: rtl/cofre_senha.sv
// cofre_senha: password lock fed by the keypad scanner; the first valid entry programs the password,
// later entries open the lock, and repeated wrong entries trigger a timed lockout.
module cofre_senha #(
    parameter int MAX_TENTATIVAS = 3,
    parameter int OPEN_CYCLES    = 250000000,
    parameter int BLOCK_CYCLES   = 500000000,
    parameter int TIMER_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digitos,
    input  logic        salve,
    output logic        aberto,
    output logic        bloqueado,
    output logic        senha_definida,
    output logic        erro,
    output logic [2:0]  tentativas
);
    typedef enum logic [1:0] {SETUP, LOCKED, OPEN, BLOCKED} state_t;
    localparam logic [2:0]         MAX_T   = 3'(MAX_TENTATIVAS);
    localparam logic [TIMER_W-1:0] T_OPEN  = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_BLOCK = TIMER_W'(BLOCK_CYCLES - 1);
    state_t             state, nstate;
    logic [15:0]        senha, nsenha;
    logic [TIMER_W-1:0] timer, ntimer;
    logic [2:0]         ntent;
    logic               ndef, nerro, salve_d, ev, valid, tmo;
    assign ev    = salve & ~salve_d;
    assign valid = (digitos[15:12] <= 4'd9) && (digitos[11:8] <= 4'd9) &&
                   (digitos[7:4] <= 4'd9) && (digitos[3:0] <= 4'd9);
    assign tmo   = (timer == '0);
    always_comb begin
        nstate = state;
        nsenha = senha;
        ntimer = timer;
        ntent  = tentativas;
        ndef   = senha_definida;
        nerro  = 1'b0;
        case (state)
            SETUP: if (ev) begin
                if (valid) begin
                    nsenha = digitos;
                    ndef   = 1'b1;
                    nstate = LOCKED;
                end else nerro = 1'b1;
            end
            LOCKED: if (ev) begin
                if (valid && digitos == senha) begin
                    ntent  = '0;
                    ntimer = T_OPEN;
                    nstate = OPEN;
                end else begin
                    nerro = 1'b1;
                    ntent = tentativas + 3'd1;
                    if (ntent == MAX_T) begin
                        ntimer = T_BLOCK;
                        nstate = BLOCKED;
                    end
                end
            end
            OPEN: begin
                ntimer = tmo ? timer : timer - TIMER_W'(1);
                nstate = tmo ? LOCKED : OPEN;
                // an entry on the expiry edge still wins so a password change is never lost
                if (ev) begin
                    if (valid) begin
                        nsenha = digitos;
                        nstate = LOCKED;
                    end else nerro = 1'b1;
                end
            end
            BLOCKED: begin
                ntimer = tmo ? timer : timer - TIMER_W'(1);
                nstate = tmo ? LOCKED : BLOCKED;
                ntent  = tmo ? 3'd0 : tentativas;
            end
            default: nstate = SETUP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= SETUP;
            senha          <= '0;
            timer          <= '0;
            tentativas     <= '0;
            senha_definida <= 1'b0;
            erro           <= 1'b0;
            aberto         <= 1'b0;
            bloqueado      <= 1'b0;
            salve_d        <= 1'b1;
        end else begin
            state          <= nstate;
            senha          <= nsenha;
            timer          <= ntimer;
            tentativas     <= ntent;
            senha_definida <= ndef;
            erro           <= nerro;
            aberto         <= (nstate == OPEN);
            bloqueado      <= (nstate == BLOCKED);
            salve_d        <= salve;
        end
    end
endmodule

// File: tb/tb_cofre_senha.sv
// tb_cofre_senha: directed checks of setup, open timing, wrong-entry counting, lockout,
// password change, held salve and reset behaviour.
module tb_cofre_senha;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digitos = '0;
    logic        salve = 1'b0;
    logic        aberto, bloqueado, senha_definida, erro;
    logic [2:0]  tentativas;
    int          checks = 0;
    int          errors = 0;
    int          n, e, a;

    cofre_senha #(.MAX_TENTATIVAS(3), .OPEN_CYCLES(8), .BLOCK_CYCLES(16), .TIMER_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .digitos(digitos), .salve(salve),
        .aberto(aberto), .bloqueado(bloqueado), .senha_definida(senha_definida),
        .erro(erro), .tentativas(tentativas)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one-cycle salve pulse; returns on the falling edge right after the evaluating edge
    task automatic entry(input logic [15:0] d);
        @(negedge clk);
        digitos = d;
        salve = 1'b1;
        @(negedge clk);
        salve = 1'b0;
        digitos = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_aberto", aberto, 0);
        chk("rst_bloq", bloqueado, 0);
        chk("rst_def", senha_definida, 0);
        chk("rst_erro", erro, 0);
        chk("rst_tent", tentativas, 0);
        rst_n = 1'b1;

        entry(16'h1234);
        chk("setup_def", senha_definida, 1);
        chk("setup_erro", erro, 0);
        chk("setup_aberto", aberto, 0);
        entry(16'h1234);
        n = 0;
        repeat (20) begin
            if (aberto) n++;
            @(negedge clk);
        end
        chk("open_len", n, 8);
        chk("open_end", aberto, 0);

        do_reset();
        entry(16'h12A4);
        chk("inv_setup_erro", erro, 1);
        chk("inv_setup_def", senha_definida, 0);
        @(negedge clk);
        chk("erro_one_cycle", erro, 0);
        entry(16'h0000);
        chk("zero_def", senha_definida, 1);
        entry(16'h0000);
        chk("zero_open", aberto, 1);

        do_reset();
        entry(16'h1234);
        entry(16'h1111);
        chk("wrong1_erro", erro, 1);
        chk("wrong1_tent", tentativas, 1);
        entry(16'h2222);
        chk("wrong2_erro", erro, 1);
        chk("wrong2_tent", tentativas, 2);
        entry(16'h1234);
        chk("right_open", aberto, 1);
        chk("right_tent", tentativas, 0);
        repeat (10) @(negedge clk);
        chk("relocked", aberto, 0);

        entry(16'h0001);
        entry(16'h0002);
        entry(16'h0003);
        chk("block_bloq", bloqueado, 1);
        chk("block_tent", tentativas, 3);
        chk("block_erro", erro, 1);
        n = 0; e = 0; a = 0;
        for (int i = 0; i < 30; i++) begin
            if (bloqueado) n++;
            if (erro && i > 0) e++;
            if (aberto) a++;
            salve = (i == 3);
            digitos = (i == 3) ? 16'h1234 : 16'h0000;
            @(negedge clk);
        end
        chk("block_len", n, 16);
        chk("block_no_erro", e, 0);
        chk("block_no_open", a, 0);
        chk("block_tent_clr", tentativas, 0);
        entry(16'h1234);
        chk("after_block_open", aberto, 1);

        entry(16'h9876);
        chk("chg_locked", aberto, 0);
        chk("chg_erro", erro, 0);
        entry(16'h1234);
        chk("old_pw_erro", erro, 1);
        chk("old_pw_tent", tentativas, 1);
        entry(16'h9876);
        chk("new_pw_open", aberto, 1);
        chk("new_pw_tent", tentativas, 0);
        entry(16'h12A4);
        chk("open_inv_erro", erro, 1);
        chk("open_inv_stays", aberto, 1);
        repeat (10) @(negedge clk);
        chk("open_inv_expired", aberto, 0);

        @(negedge clk);
        digitos = 16'h5555;
        salve = 1'b1;
        e = 0;
        repeat (10) begin
            @(negedge clk);
            if (erro) e++;
        end
        salve = 1'b0;
        digitos = '0;
        chk("held_one_eval", e, 1);
        chk("held_tent", tentativas, 1);

        @(negedge clk);
        rst_n = 1'b0;
        salve = 1'b1;
        digitos = 16'h1234;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_rst_def", senha_definida, 0);
        chk("held_rst_erro", erro, 0);
        salve = 1'b0;
        @(negedge clk);
        chk("held_rst_low", senha_definida, 0);
        salve = 1'b1;
        @(negedge clk);
        chk("held_rst_rise", senha_definida, 1);
        salve = 1'b0;
        digitos = '0;
        entry(16'h1234);
        chk("mid_open", aberto, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_aberto", aberto, 0);
        chk("midrst_def", senha_definida, 0);
        chk("midrst_bloq", bloqueado, 0);
        chk("midrst_tent", tentativas, 0);
        rst_n = 1'b1;
        entry(16'h4321);
        chk("midrst_setup", senha_definida, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cofre_senha.md
Name: cofre_senha

Overview:
- Password-lock controller directly downstream of the 3-column keypad scanner.
- Consumes the scanner's 4-digit BCD entry register and its enter/save strobe ("salve").
- First valid entry after reset programs the password. Later entries are compared against it, driving open, error and lockout status to the LEDs/actuator stage.
- Pure synchronous FSM with attempt counter and one shared down-counter timer.

Parameters:
- MAX_TENTATIVAS, 3, consecutive wrong entries that trigger lockout (range 1..7).
- OPEN_CYCLES, 250000000, clock cycles the lock stays open (5 s at 50 MHz); minimum 1.
- BLOCK_CYCLES, 500000000, clock cycles of lockout (10 s at 50 MHz); minimum 1.
- TIMER_W, 32, timer width; must hold max(OPEN_CYCLES, BLOCK_CYCLES).

Ports:
- clk, input, 1, system clock (same clock as keypad scanner).
- rst_n, input, 1, synchronous active-low reset.
- digitos, input, 16, BCD entry: [15:12] oldest digit .. [3:0] newest digit.
- salve, input, 1, level from scanner; high while the '*' key is held.
- aberto, output, 1, lock open.
- bloqueado, output, 1, lockout active.
- senha_definida, output, 1, password has been programmed.
- erro, output, 1, one-cycle pulse on a rejected entry.
- tentativas, output, 3, current count of consecutive wrong entries.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=SETUP, senha=0, timer=0, tentativas=0, aberto=0, bloqueado=0, senha_definida=0, erro=0, salve_d=1.
- Reset has priority over every other event, including mid-OPEN and mid-BLOCKED.
- Entry event: at a clk edge where salve=1 and salve_d=0; salve_d <= salve on every edge. Only the first edge of a held salve counts.
- salve_d resets to 1, so a salve held across reset release is ignored until it drops and rises again.
- digitos is sampled on the entry-event edge. The scanner zeroes digitos after salve falls, so no later sample is valid.
- Valid entry: every nibble <= 9.
- All outputs registered; response is visible after the entry-event edge (1-cycle latency).
- erro is high for exactly one cycle per rejection; all other outputs are levels.
- SETUP:
  - valid entry: senha <= digitos, senha_definida <= 1, go to LOCKED.
  - invalid entry: erro pulse, stay in SETUP.
- LOCKED (aberto=0, bloqueado=0):
  - valid entry equal to senha: tentativas <= 0, timer <= OPEN_CYCLES-1, go to OPEN.
  - any other entry (mismatch or invalid): erro pulse, tentativas += 1.
  - if the incremented count equals MAX_TENTATIVAS: timer <= BLOCK_CYCLES-1, go to BLOCKED. tentativas holds MAX_TENTATIVAS while blocked.
- OPEN (aberto=1):
  - timer decrements each cycle; on the cycle timer==0, go to LOCKED.
  - valid entry: password change, senha <= digitos, go to LOCKED immediately.
  - invalid entry: erro pulse, timer keeps running.
  - entry event and timer==0 on the same edge: the entry wins; a valid entry updates senha. End state is LOCKED either way.
- BLOCKED (bloqueado=1):
  - entry events are ignored: no erro, tentativas unchanged.
  - timer decrements; at timer==0: tentativas <= 0, go to LOCKED.
- Open duration is exactly OPEN_CYCLES cycles of aberto=1; lockout is exactly BLOCK_CYCLES cycles of bloqueado=1.
- Comparison is a full 16-bit equality; no partial or leading-zero matching (0000 is a legal password).
- Unused state encodings recover to SETUP on the next edge.

Test Plan (TB params: OPEN_CYCLES=8, BLOCK_CYCLES=16, MAX_TENTATIVAS=3):
- Reset, then salve pulse with digitos=16'h1234 → senha_definida=1 one cycle after the rise. A second entry 16'h1234 → aberto=1 for exactly 8 cycles, then 0.
- SETUP with digitos=16'h12A4 and a salve rise → erro=1 for one cycle, senha_definida stays 0. Then 16'h0000 → accepted as the password.
- Password 16'h1234; entries 16'h1111, 16'h2222 → tentativas=1 then 2, two erro pulses. Then 16'h1234 → aberto=1, tentativas=0.
- Three wrong entries → bloqueado=1 for 16 cycles, tentativas=3. A correct 16'h1234 during lockout is ignored (no erro, aberto stays 0). After lockout, tentativas=0 and 16'h1234 opens.
- While OPEN, entry 16'h9876 → immediate LOCKED. 16'h1234 now fails with erro; 16'h9876 opens.
- salve held high for 10 cycles → exactly one evaluation. salve high while rst_n deasserts → no evaluation until salve toggles low then high. rst_n=0 mid-OPEN → all outputs 0, state SETUP on the next edge.
